// File: rtl/pc_update_reg_pkg.sv
// Shared constants for the registered Y86-64 next-PC unit: instruction codes,
// status codes and FSM state encodings.
package pc_update_reg_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SINS = 3'd4;

   // State encoding doubles as the stat output.
   localparam logic [2:0] ST_RUN  = SAOK;
   localparam logic [2:0] ST_HALT = SHLT;
   localparam logic [2:0] ST_ERR  = SINS;

endpackage

// File: rtl/pc_update_reg_ras_stack.sv
// Circular return-address stack: push/pop at the top, drops the oldest entry
// on overflow, and keeps top/count/full registered.
module ras_stack #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic [CNT_W-1:0]  count,
   output logic              full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] top_q, top_d;
   logic              full_q;

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      top_d   = top_q;
      if (push) begin
         // Pointer wraps onto the oldest slot once full; count saturates.
         ptr_d = ptr_q + PTR_W'(1);
         top_d = din;
         if (count_q != CNT_W'(DEPTH)) begin
            count_d = count_q + CNT_W'(1);
         end
      end else if (pop && (count_q != '0)) begin
         ptr_d   = ptr_q - PTR_W'(1);
         count_d = count_q - CNT_W'(1);
         top_d   = (count_q > CNT_W'(1)) ? mem[ptr_d] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         top_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         top_q   <= top_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr_d] <= din;
      end
   end

   assign top   = top_q;
   assign count = count_q;
   assign full  = full_q;

endmodule

// File: rtl/pc_update_reg.sv
// Registered next-PC unit for the Y86-64 fetch stage with status tracking and
// a return-address stack that checks each ret target against valm.
module pc_update_reg
   import pc_update_reg_pkg::*;
#(
   parameter int unsigned     ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned     RAS_DEPTH = 8,
   parameter int unsigned     CNT_W     = $clog2(RAS_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              stall,
   input  logic [3:0]        icode,
   input  logic              cnd,
   input  logic [ADDR_W-1:0] valc,
   input  logic [ADDR_W-1:0] valm,
   input  logic [ADDR_W-1:0] valp,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        stat,
   output logic [ADDR_W-1:0] ras_top,
   output logic [CNT_W-1:0]  ras_count,
   output logic              ras_full,
   output logic              ret_miss
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [2:0]        state_q, state_d;
   logic              miss_q, miss_d;
   logic              advance;
   logic              push, pop;

   assign advance = en & ~stall & (state_q == ST_RUN);

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      push    = 1'b0;
      pop     = 1'b0;
      miss_d  = 1'b0;
      if (advance) begin
         case (icode)
            IHALT: state_d = ST_HALT;
            INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: pc_d = valp;
            IJXX:  pc_d = cnd ? valc : valp;
            ICALL: begin
               pc_d = valc;
               push = 1'b1;
            end
            IRET: begin
               // Target always comes from memory; the stack only scores the prediction.
               pc_d   = valm;
               pop    = 1'b1;
               miss_d = (ras_count == '0) || (ras_top != valm);
            end
            default: state_d = ST_ERR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
         miss_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         miss_q  <= miss_d;
      end
   end

   ras_stack #(
      .DEPTH  (RAS_DEPTH),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (valp),
      .top   (ras_top),
      .count (ras_count),
      .full  (ras_full)
   );

   assign pc       = pc_q;
   assign stat     = state_q;
   assign ret_miss = miss_q;

endmodule

// File: tb/tb_pc_update_reg.sv
// Randomized and directed checks of pc_update_reg against a queue-based
// behavioural model of the PC, status and return-address stack.
module tb_pc_update_reg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              stall = 1'b0;
   logic [3:0]        icode = 4'h1;
   logic              cnd = 1'b0;
   logic [ADDR_W-1:0] valc = '0;
   logic [ADDR_W-1:0] valm = '0;
   logic [ADDR_W-1:0] valp = '0;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        stat;
   logic [ADDR_W-1:0] ras_top;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_full;
   logic              ret_miss;

   pc_update_reg #(
      .ADDR_W    (ADDR_W),
      .RESET_PC  ('0),
      .RAS_DEPTH (DEPTH),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .stall     (stall),
      .icode     (icode),
      .cnd       (cnd),
      .valc      (valc),
      .valm      (valm),
      .valp      (valp),
      .pc        (pc),
      .stat      (stat),
      .ras_top   (ras_top),
      .ras_count (ras_count),
      .ras_full  (ras_full),
      .ret_miss  (ret_miss)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: PC, status code, return stack as a queue (back = top).
   logic [63:0] m_pc;
   int          m_stat;
   logic [63:0] m_q[$];
   bit          m_miss;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_top();
      return (m_q.size() == 0) ? 64'd0 : m_q[$];
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".stat"}, 64'(stat), 64'(m_stat));
      check({tag, ".ras_count"}, 64'(ras_count), 64'(m_q.size()));
      check({tag, ".ras_top"}, ras_top, m_top());
      check({tag, ".ras_full"}, 64'(ras_full), 64'(m_q.size() == DEPTH));
      check({tag, ".ret_miss"}, 64'(ret_miss), 64'(m_miss));
   endtask

   // Asserted between edges so the check proves the reset is asynchronous.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      m_pc = 64'd0;
      m_stat = 1;
      m_q.delete();
      m_miss = 1'b0;
      #1;
      check_all(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic step(input string tag, input logic e, input logic s, input logic [3:0] ic,
                       input logic c, input logic [63:0] vc, input logic [63:0] vm,
                       input logic [63:0] vp);
      en = e;
      stall = s;
      icode = ic;
      cnd = c;
      valc = vc;
      valm = vm;
      valp = vp;
      m_miss = 1'b0;
      if (e && !s && m_stat == 1) begin
         if (ic == 4'h0) m_stat = 2;
         else if (ic >= 4'hC) m_stat = 4;
         else if (ic == 4'h7) m_pc = c ? vc : vp;
         else if (ic == 4'h8) begin
            m_pc = vc;
            m_q.push_back(vp);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
         end else if (ic == 4'h9) begin
            m_pc = vm;
            m_miss = (m_q.size() == 0) || (m_q[$] != vm);
            if (m_q.size() > 0) void'(m_q.pop_back());
         end else m_pc = vp;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      do_reset("reset");
      step("nop", 1, 0, 4'h1, 0, 0, 0, 64'h2);
      do_reset("midrst");
      step("jxx_t", 1, 0, 4'h7, 1, 64'hA, 0, 64'h2);
      step("jxx_nt", 1, 0, 4'h7, 0, 64'hA, 0, 64'h2);
      step("stall", 1, 1, 4'h1, 0, 0, 0, 64'h99);
      step("call", 1, 0, 4'h8, 0, 64'h20, 0, 64'h2);
      step("ret_hit", 1, 0, 4'h9, 0, 0, 64'h2, 64'h5);
      step("ret_empty", 1, 0, 4'h9, 0, 0, 64'h20, 64'h5);
      step("miss_clr", 0, 0, 4'h1, 0, 0, 0, 64'h7);
      for (int i = 1; i <= 9; i++) step("call9", 1, 0, 4'h8, 0, 64'h100 + 64'(i), 0, 64'(i));
      for (int i = 9; i >= 2; i--) step("ret8", 1, 0, 4'h9, 0, 0, 64'(i), 64'h3);
      step("ret_under", 1, 0, 4'h9, 0, 0, 64'h1, 64'h3);
      step("halt", 1, 0, 4'h0, 0, 0, 0, 64'h44);
      step("halt_hold", 1, 0, 4'h1, 0, 0, 0, 64'h55);
      do_reset("rst2");
      step("ins", 1, 0, 4'hD, 0, 0, 0, 64'h66);
      step("ins_hold", 1, 0, 4'h8, 0, 64'h77, 0, 64'h66);
      do_reset("rst3");

      for (int n = 0; n < 600; n++) begin
         int r;
         logic [3:0] ic;
         logic [63:0] vm;
         if (m_stat != 1 && ($urandom() % 4) == 0) do_reset("rnd_rst");
         r = $urandom_range(0, 99);
         if (r < 2) ic = 4'h0;
         else if (r < 4) ic = 4'(12 + $urandom_range(0, 3));
         else if (r < 30) ic = 4'h8;
         else if (r < 55) ic = 4'h9;
         else ic = 4'($urandom_range(1, 11));
         vm = (($urandom() % 2) == 0) ? m_top() : rnd64();
         step("rnd", ($urandom() % 8) != 0, ($urandom() % 6) == 0, ic, 1'($urandom()),
              rnd64(), vm, rnd64());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
